// File: rtl/sdcram_multiport_arbiter.sv
// -----------------------------------------------------------------------------
// sdcram_multiport_arbiter
//
// Round-robin arbiter/bridge that shares the single-port sdcram among
// NUM_PORTS requesters (boot loader, sdcram controller, DMA masters).
// Each requester holds a level request until it gets a one-cycle ack.
// The arbiter then runs one sdcram access on that requester's behalf.
//
// Ports
//   CLK, RST_X      clock, asynchronous active-low reset
//   i_boot_lock     1 = only port 0 takes part in arbitration
//   p_req/p_we      per-port request level and write select
//   p_addr          per-port address, port k at [k*ADDR_W +: ADDR_W]
//   p_wdata/p_be    per-port write data (32 bits) and byte enables (4 bits)
//   p_ack, p_err    one-cycle completion pulse to the owner, plus timeout flag
//   o_rdata         read data, valid with p_ack for reads
//   o_grant         one-hot current owner, 0 while idle
//   sdcram_*        single-port sdcram interface
// -----------------------------------------------------------------------------
module sdcram_multiport_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 41,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                        CLK,
   input  logic                        RST_X,
   input  logic                        i_boot_lock,
   input  logic [NUM_PORTS-1:0]        p_req,
   input  logic [NUM_PORTS-1:0]        p_we,
   input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
   input  logic [NUM_PORTS*32-1:0]     p_wdata,
   input  logic [NUM_PORTS*4-1:0]      p_be,
   output logic [NUM_PORTS-1:0]        p_ack,
   output logic                        p_err,
   output logic [31:0]                 o_rdata,
   output logic [NUM_PORTS-1:0]        o_grant,
   output logic [ADDR_W-1:0]           sdcram_addr,
   output logic                        sdcram_ren,
   output logic [3:0]                  sdcram_wen,
   output logic [31:0]                 sdcram_wdata,
   input  logic [31:0]                 sdcram_rdata,
   input  logic                        sdcram_busy
);

   localparam int                PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PTR_W:0]    NP       = (PTR_W+1)'(NUM_PORTS);
   localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_PORTS - 1);
   localparam logic [23:0]       T_LAST   = 24'(TIMEOUT_CYC - 1);
   localparam logic [NUM_PORTS-1:0] ONE   = NUM_PORTS'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t state_reg, state_next;

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] grant_idx_reg;
   logic             we_reg;
   logic [3:0]       be_reg;
   logic             err_reg;
   logic [23:0]      cnt_reg;

   // Per-port views of the packed request buses
   logic [NUM_PORTS-1:0] eligible;
   logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
   logic [31:0]          wdata_arr [NUM_PORTS];
   logic [3:0]           be_arr    [NUM_PORTS];

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign addr_arr[gi]  = p_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = p_wdata[gi*32 +: 32];
         assign be_arr[gi]    = p_be[gi*4 +: 4];
         // Boot lock leaves only port 0 eligible
         assign eligible[gi]  = p_req[gi] & (~i_boot_lock | (gi == 0));
      end
   endgenerate

   // First eligible port at or after the pointer, wrapping modulo NUM_PORTS
   logic             found;
   logic [PTR_W-1:0] pick_idx;
   logic [PTR_W:0]   cand;

   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
         if (cand >= NP) begin
            cand = cand - NP;
         end
         if (!found && eligible[cand[PTR_W-1:0]]) begin
            found    = 1'b1;
            pick_idx = cand[PTR_W-1:0];
         end
      end
   end

   // Control FSM: next state and per-cycle strobes
   logic load_grant;
   logic issue_fire;
   logic wait_done;
   logic wait_timeout;

   always_comb begin
      state_next   = state_reg;
      load_grant   = 1'b0;
      issue_fire   = 1'b0;
      wait_done    = 1'b0;
      wait_timeout = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (found) begin
               load_grant = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!sdcram_busy) begin
               issue_fire = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // cnt_reg == 0 is the cycle right after issue, where busy may
            // not yet reflect the new access, so it is never taken as done.
            if ((cnt_reg != '0) && !sdcram_busy) begin
               wait_done  = 1'b1;
               state_next = S_RESP;
            end else if (cnt_reg == T_LAST) begin
               wait_timeout = 1'b1;
               state_next   = S_RESP;
            end
         end
         S_RESP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         ptr_reg       <= '0;
         grant_idx_reg <= '0;
         we_reg        <= 1'b0;
         be_reg        <= '0;
         err_reg       <= 1'b0;
         cnt_reg       <= '0;
         o_grant       <= '0;
         o_rdata       <= '0;
         sdcram_addr   <= '0;
         sdcram_wdata  <= '0;
      end else begin
         if (load_grant) begin
            o_grant       <= ONE << pick_idx;
            grant_idx_reg <= pick_idx;
            we_reg        <= p_we[pick_idx];
            be_reg        <= be_arr[pick_idx];
            sdcram_addr   <= addr_arr[pick_idx];
            sdcram_wdata  <= wdata_arr[pick_idx];
            err_reg       <= 1'b0;
         end

         if (issue_fire) begin
            cnt_reg <= '0;
         end else if (state_reg == S_WAIT) begin
            cnt_reg <= cnt_reg + 24'd1;
         end

         if (wait_done && !we_reg) begin
            o_rdata <= sdcram_rdata;
         end

         if (wait_timeout) begin
            err_reg <= 1'b1;
         end

         if (state_reg == S_RESP) begin
            o_grant <= '0;
            ptr_reg <= (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + PTR_W'(1);
         end
      end
   end

   // Strobes exist only in the single issue cycle; a write with be=0 issues
   // no strobe but still walks through WAIT and gets acked.
   assign sdcram_ren = issue_fire & ~we_reg;
   assign sdcram_wen = (issue_fire && we_reg) ? be_reg : 4'b0000;

   assign p_ack = (state_reg == S_RESP) ? o_grant : '0;
   assign p_err = (state_reg == S_RESP) & err_reg;

endmodule

// File: tb/tb_sdcram_multiport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdcram_multiport_arbiter
//
// Directed bench for sdcram_multiport_arbiter with three ports and a short
// busy timeout. A small sdcram model answers strobes with a programmable
// busy length (or a stuck-busy mode) and returns a fixed read word.
// -----------------------------------------------------------------------------
module tb_sdcram_multiport_arbiter;

   localparam int NP = 3;
   localparam int AW = 41;

   logic              CLK;
   logic              RST_X;
   logic              i_boot_lock;
   logic [NP-1:0]     p_req;
   logic [NP-1:0]     p_we;
   logic [NP*AW-1:0]  p_addr;
   logic [NP*32-1:0]  p_wdata;
   logic [NP*4-1:0]   p_be;
   logic [NP-1:0]     p_ack;
   logic              p_err;
   logic [31:0]       o_rdata;
   logic [NP-1:0]     o_grant;
   logic [AW-1:0]     sdcram_addr;
   logic              sdcram_ren;
   logic [3:0]        sdcram_wen;
   logic [31:0]       sdcram_wdata;
   logic [31:0]       sdcram_rdata;
   logic              sdcram_busy;

   sdcram_multiport_arbiter #(
      .NUM_PORTS   (NP),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (10)
   ) dut (
      .CLK          (CLK),
      .RST_X        (RST_X),
      .i_boot_lock  (i_boot_lock),
      .p_req        (p_req),
      .p_we         (p_we),
      .p_addr       (p_addr),
      .p_wdata      (p_wdata),
      .p_be         (p_be),
      .p_ack        (p_ack),
      .p_err        (p_err),
      .o_rdata      (o_rdata),
      .o_grant      (o_grant),
      .sdcram_addr  (sdcram_addr),
      .sdcram_ren   (sdcram_ren),
      .sdcram_wen   (sdcram_wen),
      .sdcram_wdata (sdcram_wdata),
      .sdcram_rdata (sdcram_rdata),
      .sdcram_busy  (sdcram_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- sdcram model and strobe monitor ----------------
   int          busy_len   = 0;
   bit          stick_mode = 1'b0;
   logic [31:0] rd_value   = 32'h0;
   int          busy_cnt   = 0;
   bit          stuck      = 1'b0;
   int          ren_cnt    = 0;
   int          wen_cnt    = 0;
   logic [AW-1:0] last_addr  = '0;
   logic [31:0]   last_wdata = '0;
   logic [3:0]    last_wen   = '0;

   assign sdcram_busy  = stuck || (busy_cnt != 0);
   assign sdcram_rdata = rd_value;

   always @(posedge CLK) begin
      if (sdcram_ren || (sdcram_wen != 4'b0000)) begin
         busy_cnt  <= busy_len;
         last_addr <= sdcram_addr;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      if (!stick_mode) begin
         stuck <= 1'b0;
      end else if (sdcram_ren || (sdcram_wen != 4'b0000)) begin
         stuck <= 1'b1;
      end
      if (sdcram_ren) begin
         ren_cnt <= ren_cnt + 1;
      end
      if (sdcram_wen != 4'b0000) begin
         wen_cnt    <= wen_cnt + 1;
         last_wen   <= sdcram_wen;
         last_wdata <= sdcram_wdata;
      end
   end

   // ---------------- checking helpers ----------------
   int passed = 0;
   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int k, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
      p_we[k]             = we;
      p_addr[k*AW +: AW]  = addr;
      p_wdata[k*32 +: 32] = wd;
      p_be[k*4 +: 4]      = be;
   endtask

   // Counts negedges until p_ack shows up (bounded)
   task automatic wait_ack(input string tag, output int lat);
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while ((p_ack == '0) && (lat < 100));
      chk(tag, (p_ack != '0), 1'b1);
      $display("ack %s: p_ack=%b p_err=%b o_rdata=0x%08h latency=%0d", tag, p_ack, p_err, o_rdata, lat);
   endtask

   // ---------------- stimulus ----------------
   logic [NP-1:0] rr_exp [3];
   int lat;
   int r0, w0;

   initial begin
      rr_exp      = '{3'b001, 3'b010, 3'b100};
      RST_X       = 1'b0;
      i_boot_lock = 1'b0;
      p_req       = '0;
      p_we        = '0;
      p_addr      = '0;
      p_wdata     = '0;
      p_be        = '0;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_grant",  o_grant,      0);
      chk("rst_ack",    p_ack,        0);
      chk("rst_err",    p_err,        0);
      chk("rst_rdata",  o_rdata,      0);
      chk("rst_ren",    sdcram_ren,   0);
      chk("rst_wen",    sdcram_wen,   0);
      chk("rst_addr",   sdcram_addr,  0);
      chk("rst_wdata",  sdcram_wdata, 0);
      RST_X = 1'b1;
      @(negedge CLK);

      // Single read, port 1, busy high 3 cycles
      rd_value = 32'hDEADBEEF;
      busy_len = 3;
      set_port(1, 1'b0, 41'h0_0000_1000, 32'h0, 4'h0);
      r0 = ren_cnt; w0 = wen_cnt;
      p_req = 3'b010;
      wait_ack("rd_ack_seen", lat);
      chk("rd_ack",     p_ack,         3'b010);
      chk("rd_err",     p_err,         0);
      chk("rd_rdata",   o_rdata,       32'hDEADBEEF);
      chk("rd_grant",   o_grant,       3'b010);
      chk("rd_latency", lat,           6);
      chk("rd_ren_cnt", ren_cnt - r0,  1);
      chk("rd_wen_cnt", wen_cnt - w0,  0);
      chk("rd_addr",    last_addr,     41'h0_0000_1000);
      p_req = '0;
      @(negedge CLK);
      chk("rd_idle_grant", o_grant, 0);

      // Write, port 0, be=0110
      rd_value = 32'hCAFEF00D;
      busy_len = 2;
      set_port(0, 1'b1, 41'h1_2345_6780, 32'h11223344, 4'b0110);
      r0 = ren_cnt; w0 = wen_cnt;
      p_req = 3'b001;
      wait_ack("wr_ack_seen", lat);
      chk("wr_ack",     p_ack,         3'b001);
      chk("wr_err",     p_err,         0);
      chk("wr_rdata",   o_rdata,       32'hDEADBEEF);
      chk("wr_wen_cnt", wen_cnt - w0,  1);
      chk("wr_ren_cnt", ren_cnt - r0,  0);
      chk("wr_wen",     last_wen,      4'b0110);
      chk("wr_wdata",   last_wdata,    32'h11223344);
      chk("wr_addr",    last_addr,     41'h1_2345_6780);
      p_req = '0;
      @(negedge CLK);
      chk("wr_addr_hold", sdcram_addr, 41'h1_2345_6780);

      // Minimum latency read, port 2, busy never raised
      busy_len = 0;
      set_port(2, 1'b0, 41'h0_0000_0ABC, 32'h0, 4'h0);
      p_req = 3'b100;
      wait_ack("lat_ack_seen", lat);
      chk("lat_cycles", lat,     4);
      chk("lat_ack",    p_ack,   3'b100);
      chk("lat_rdata",  o_rdata, 32'hCAFEF00D);
      p_req = '0;
      @(negedge CLK);

      // Write with be=0: no strobe, still acked
      busy_len = 1;
      set_port(1, 1'b1, 41'h0_0000_0040, 32'hFFFF0000, 4'b0000);
      r0 = ren_cnt; w0 = wen_cnt;
      p_req = 3'b010;
      wait_ack("be0_ack_seen", lat);
      chk("be0_ack",     p_ack,        3'b010);
      chk("be0_err",     p_err,        0);
      chk("be0_wen_cnt", wen_cnt - w0, 0);
      chk("be0_ren_cnt", ren_cnt - r0, 0);
      p_req = '0;
      @(negedge CLK);

      // Reset pulse so the round-robin pointer starts at 0
      RST_X = 1'b0;
      @(negedge CLK);
      RST_X = 1'b1;
      @(negedge CLK);

      // Round robin with all three ports requesting
      rd_value = 32'h5A5A0001;
      busy_len = 1;
      set_port(0, 1'b0, 41'h100, 32'h0, 4'h0);
      set_port(1, 1'b0, 41'h200, 32'h0, 4'h0);
      set_port(2, 1'b0, 41'h300, 32'h0, 4'h0);
      p_req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         wait_ack("rr_ack_seen", lat);
         chk("rr_grant", p_ack, rr_exp[k % 3]);
      end

      // Boot lock: ports 0 and 1 request, only port 0 served
      i_boot_lock = 1'b1;
      p_req = 3'b011;
      for (int k = 0; k < 3; k++) begin
         wait_ack("lock_ack_seen", lat);
         chk("lock_grant", p_ack, 3'b001);
      end
      i_boot_lock = 1'b0;
      wait_ack("unlock_ack_seen", lat);
      chk("unlock_grant", p_ack, 3'b010);
      p_req = '0;
      @(negedge CLK);

      // Busy stuck high after issue -> timeout after 10 WAIT cycles
      rd_value   = 32'hBADBAD00;
      busy_len   = 0;
      stick_mode = 1'b1;
      set_port(0, 1'b0, 41'h77, 32'h0, 4'h0);
      p_req = 3'b001;
      wait_ack("to_ack_seen", lat);
      chk("to_ack",     p_ack,   3'b001);
      chk("to_err",     p_err,   1);
      chk("to_latency", lat,     12);
      chk("to_rdata",   o_rdata, 32'h5A5A0001);
      stick_mode = 1'b0;
      wait_ack("after_to_ack_seen", lat);
      chk("after_to_ack",   p_ack,   3'b001);
      chk("after_to_err",   p_err,   0);
      chk("after_to_rdata", o_rdata, 32'hBADBAD00);
      p_req = '0;
      @(negedge CLK);

      // Reset asserted during WAIT abandons the access
      rd_value = 32'h600DF00D;
      busy_len = 5;
      set_port(1, 1'b0, 41'h1_0000_0010, 32'h0, 4'h0);
      r0 = ren_cnt;
      p_req = 3'b010;
      repeat (3) @(negedge CLK);
      chk("mid_grant",   o_grant,      3'b010);
      chk("mid_ren_cnt", ren_cnt - r0, 1);
      RST_X = 1'b0;
      #1;
      chk("mid_rst_grant", o_grant,      0);
      chk("mid_rst_ack",   p_ack,        0);
      chk("mid_rst_err",   p_err,        0);
      chk("mid_rst_rdata", o_rdata,      0);
      chk("mid_rst_addr",  sdcram_addr,  0);
      chk("mid_rst_ren",   sdcram_ren,   0);
      chk("mid_rst_wen",   sdcram_wen,   0);
      chk("mid_rst_wdata", sdcram_wdata, 0);
      @(negedge CLK);
      chk("mid_rst_ack2", p_ack, 0);
      RST_X = 1'b1;
      wait_ack("rearb_ack_seen", lat);
      chk("rearb_ack",   p_ack,   3'b010);
      chk("rearb_err",   p_err,   0);
      chk("rearb_rdata", o_rdata, 32'h600DF00D);
      p_req = '0;
      repeat (2) @(negedge CLK);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sdcram_multiport_arbiter.md
Name: sdcram_multiport_arbiter

Overview:
Parametrised N-port arbiter/bridge in front of the single-port SD-card RAM (sdcram) interface. It replaces the fixed loader-vs-controller mux with round-robin arbitration over NUM_PORTS requesters using a level req/ack handshake. It adds byte-enable writes, a boot-lock mode that grants only port 0, and a busy-timeout error. It sits between the boot loader, sdcram controller, and any future DMA masters and the sdcram.

Parameters:
NUM_PORTS, 2, number of requesting ports (1..8)
ADDR_W, 41, sdcram address width
TIMEOUT_CYC, 65535, maximum cycles sdcram_busy may stay high per access before an error is flagged (1..2^24-1)

Ports:
CLK  in  1  clock
RST_X  in  1  asynchronous active-low reset
i_boot_lock  in  1  1 = only port 0 may be granted (boot loader phase)
p_req  in  NUM_PORTS  per-port request level; held until ack
p_we  in  NUM_PORTS  per-port 1 = write, 0 = read
p_addr  in  NUM_PORTS*ADDR_W  per-port address, port k at [k*ADDR_W +: ADDR_W]
p_wdata  in  NUM_PORTS*32  per-port write data
p_be  in  NUM_PORTS*4  per-port byte enables (write only)
p_ack  out  NUM_PORTS  one-cycle completion pulse to the granted port
p_err  out  1  valid with p_ack; 1 = timeout on this access
o_rdata  out  32  read data, valid in the p_ack cycle for reads
o_grant  out  NUM_PORTS  one-hot current owner; 0 when idle
sdcram_addr  out  ADDR_W  to sdcram
sdcram_ren  out  1  read strobe
sdcram_wen  out  4  write byte strobes
sdcram_wdata  out  32  write data
sdcram_rdata  in  32  read data
sdcram_busy  in  1  sdcram busy

Behaviour:
- Reset (RST_X low, async): FSM=IDLE, all outputs 0, round-robin pointer=0, timeout counter=0. Reset asserted mid-access abandons it with no ack; the port re-requests.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: eligible = p_req masked by (i_boot_lock ? 1'b1 at bit 0 only : all ones). Pick the first eligible port at or after the pointer, wrapping modulo NUM_PORTS. Register the grant, we, addr, wdata, and be, then go to ISSUE. With no eligible port, stay in IDLE.
- ISSUE: wait until sdcram_busy=0. In that cycle drive sdcram_ren=~we or sdcram_wen=(we ? be : 0) for exactly one cycle, with addr/wdata from the registers. Go to WAIT and clear the counter. A write with be=0 still completes normally (no strobe, ack given).
- WAIT: the first cycle after issue is ignored (busy latency). From the second cycle on, sdcram_busy=0 means done: capture sdcram_rdata into o_rdata (reads only; writes leave o_rdata unchanged) and go to RESP. The counter increments each WAIT cycle. Reaching TIMEOUT_CYC sets the error flag and goes to RESP without capturing data.
- RESP: pulse p_ack[grant] for 1 cycle with p_err=flag. Set pointer=grant+1 (wrap to 0 past NUM_PORTS-1). Clear o_grant and go to IDLE. A port must drop or re-evaluate req in the cycle after ack. A held req counts as a new request, but the next arbitration is fair, so another eligible port wins first.
- sdcram_addr/wdata hold the registered values from ISSUE until the next grant. ren/wen are 0 outside the issue cycle.
- i_boot_lock changing mid-access does not abort the access; it only affects the next arbitration.
- Minimum latency: req to ack = 4 cycles (IDLE→ISSUE→WAIT x2 with busy low→RESP), measured from the req cycle to the ack cycle when busy stays 0.
- Requests from out-of-range or masked ports are never acked while masked.

Test Plan:
- Single read, port 1, addr 0x0_0000_1000. sdcram returns 0xDEADBEEF with busy high for 3 cycles → exactly one ren pulse with addr 0x1000; p_ack=2'b10, o_rdata=0xDEADBEEF, p_err=0.
- Write from port 0 with be=4'b0110, wdata=0x11223344 → sdcram_wen=4'b0110 for one cycle, wdata 0x11223344, ack to port 0 only, o_rdata unchanged.
- NUM_PORTS=3, all ports hold req continuously → grants in order 0,1,2,0,…; each port receives exactly one ack per three accesses.
- i_boot_lock=1 with p_req=2'b11 → only port 0 is granted and acked repeatedly. Lower the lock → port 1 is granted next.
- TIMEOUT_CYC=10, sdcram_busy stuck high after issue → p_ack with p_err=1 after 10 WAIT cycles. The next access with normal busy has p_err=0.
- Deassert RST_X during WAIT → all outputs 0 immediately, no ack. After release, the pending req is re-arbitrated and completes.
